// File: rtl/mmio_arbiter.sv
`timescale 1ns/1ps
// Two-requester MMIO arbiter: grants one request, issues a one-cycle strobe, returns a one-cycle response.
// Latency: accept T, strobe T+1, response T+2. Optional round-robin tie-break with MMIO_ARB_RR_EN (default: requester 0 wins).
module mmio_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_wr,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state;
  logic       gnt;
  logic       gnt_q;
  logic       wr_q;
  logic [1:0] rsp_q;
  logic       hs;

`ifdef MMIO_ARB_RR_EN
  logic last_q;

  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b10)
      gnt = 1'b1;
    else if (req_valid == 2'b11)
      gnt = ~last_q;
  end
`else
  always_comb begin
    gnt = (req_valid == 2'b10);
  end
`endif

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst)
      req_ready[gnt] = req_valid[gnt];
  end

  assign hs = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      rsp_q   <= 2'b00;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
      m_wr    <= 1'b0;
      m_rd    <= 1'b0;
`ifdef MMIO_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_q <= 2'b00;
          if (hs) begin
            gnt_q   <= gnt;
            wr_q    <= req_wr[gnt];
            m_addr  <= gnt ? req_addr[63:32]  : req_addr[31:0];
            m_wdata <= gnt ? req_wdata[63:32] : req_wdata[31:0];
            m_wr    <= req_wr[gnt];
            m_rd    <= ~req_wr[gnt];
            state   <= ISSUE;
`ifdef MMIO_ARB_RR_EN
            last_q  <= gnt;
`endif
          end
        end
        ISSUE: begin
          m_wr  <= 1'b0;
          m_rd  <= 1'b0;
          rsp_q <= gnt_q ? 2'b10 : 2'b01;
          state <= RESP;
        end
        RESP: begin
          rsp_q <= 2'b00;
          state <= IDLE;
        end
        default: begin
          m_wr  <= 1'b0;
          m_rd  <= 1'b0;
          rsp_q <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  // The slave registers read data on the strobe edge, so it is valid only during RESP;
  // a reset asserted in RESP suppresses the pulse already in flight.
  assign rsp_valid = rst ? 2'b00 : rsp_q;
  assign rsp_data  = (|rsp_valid && !wr_q) ? m_rdata : 32'h0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mmio_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mmio_arbiter with a small register-file slave model.
module tb_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wr;
  logic        m_rd;
  logic [31:0] m_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic gl [0:3];
  logic [31:0] mem [0:15];

  mmio_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_rd(m_rd),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave: word register file; 0x8008 is a read-only register holding 0x3A.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
    end else begin
      if (m_wr) mem[m_addr[5:2]] <= m_wdata;
      if (m_rd) m_rdata <= (m_addr == 32'h8008) ? 32'h3A : mem[m_addr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd);
    int n = 0;
    logic [1:0] onehot;
    onehot = 2'b01 << i;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_wr[i] = wr;
    req_addr[i*32 +: 32] = addr;
    req_wdata[i*32 +: 32] = data;
    #1;
    while (!req_ready[i] && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("txn_ready", req_ready, onehot);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check("issue_busy", busy, 1);
    check("issue_wr", m_wr, wr);
    check("issue_rd", m_rd, !wr);
    check("issue_addr", m_addr, addr);
    check("issue_wdata", m_wdata, data);
    check("issue_rsp", rsp_valid, 0);
    @(negedge clk);
    check("resp_valid", rsp_valid, onehot);
    check("resp_data", rsp_data, exp_rd);
    check("resp_strobe", {m_wr, m_rd}, 0);
    check("resp_addr", m_addr, addr);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rsp", rsp_valid, 0);
    check("idle_data", rsp_data, 0);
  endtask

  task automatic burst(input logic [1:0] vld, input int n);
    int acc = 0, cyc = 0, last = 0, dbl = 0;
    logic prev_s = 1'b0;
    @(negedge clk);
    req_valid = vld;
    req_wr = 2'b00;
    req_addr = {32'h8004, 32'h8000};
    #1;
    while (acc < n && cyc < 40) begin
      if ((m_rd | m_wr) && prev_s) dbl++;
      prev_s = m_rd | m_wr;
      if (req_ready != 2'b00) begin
        gl[acc] = req_ready[1];
        if (acc > 0) check("accept_gap", cyc - last, 3);
        last = cyc;
        acc++;
      end
      @(negedge clk); #1; cyc++;
    end
    req_valid = 2'b00;
    check("accept_count", acc, n);
    check("no_b2b_strobe", dbl, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic exp_g [0:3];
    rst = 1'b1;
    req_valid = 2'b11;
    req_wr = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", {m_wr, m_rd}, 0);
    check("rst_addr", m_addr, 0);
    check("rst_wdata", m_wdata, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    rst = 1'b0;
    req_valid = 2'b00;

    // Single write, write-then-read, read-back through the other requester.
    do_txn(0, 1'b1, 32'h8000, 32'h5, 32'h0);
    do_txn(0, 1'b1, 32'h8004, 32'h10, 32'h0);
    do_txn(1, 1'b0, 32'h8008, 32'h0, 32'h3A);
    do_txn(1, 1'b0, 32'h8000, 32'h0, 32'h5);
    do_txn(0, 1'b0, 32'h8004, 32'h0, 32'h10);

    // Request arriving mid-transaction waits, then withdraws before its handshake.
    @(negedge clk);
    req_valid = 2'b01; req_wr = 2'b01; req_addr = {32'h8000, 32'h8010}; req_wdata = 64'h7;
    #1;
    check("wait_ready0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(negedge clk);
    check("wait_issue", req_ready, 0);
    @(negedge clk);
    check("wait_resp", req_ready, 0);
    check("wait_rsp0", rsp_valid, 2'b01);
    @(negedge clk);
    check("wait_granted", req_ready, 2'b10);
    req_valid = 2'b00;
    @(negedge clk);
    check("drop_busy", busy, 0);
    @(negedge clk);
    check("drop_rsp", rsp_valid, 0);

    // Reset during ISSUE of a read aborts it.
    @(negedge clk);
    req_valid = 2'b10; req_wr = 2'b00; req_addr = {32'h8008, 32'h0};
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_rd_before", m_rd, 1);
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", req_ready, 0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rd", m_rd, 0);
    check("abort_rsp", rsp_valid, 0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", req_ready, 2'b10);
    req_valid = 2'b00;
    @(negedge clk);

    // Both requesters continuously valid.
`ifdef MMIO_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    burst(2'b11, 4);
    for (int k = 0; k < 4; k++) check($sformatf("tie_grant%0d", k), gl[k], exp_g[k]);

    // Requester 0 alone, back-to-back.
    burst(2'b01, 3);
    for (int k = 0; k < 3; k++) check($sformatf("solo_grant%0d", k), gl[k], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
